// File: rtl/cond_unit.sv
// Execute-stage ARM condition/flag unit: NZCV register, condition evaluation, E->M pipeline register.
// Optional squash counter enabled by defining COND_SQUASH_CNT_EN.
module cond_unit #(
  parameter int N = 32
`ifdef COND_SQUASH_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_e,
  input  logic [3:0]       cond_e,
  input  logic [1:0]       flag_w_e,
  input  logic             pc_s_e,
  input  logic             reg_w_e,
  input  logic             mem_w_e,
  input  logic [3:0]       wa3_e,
  input  logic [3:0]       alu_flags,
  input  logic [N-1:0]     alu_result,
  output logic [3:0]       flags,
  output logic             cond_ex_e,
  output logic             pc_src_e,
  output logic             valid_m,
  output logic             reg_w_m,
  output logic             mem_w_m,
  output logic [3:0]       wa3_m,
  output logic [N-1:0]     alu_result_m
`ifdef COND_SQUASH_CNT_EN
  , output logic [CNT_W-1:0] squash_cnt
`endif
);

  logic [3:0]   flags_q, flags_d;
  logic         valid_m_q, valid_m_d;
  logic         reg_w_m_q, reg_w_m_d;
  logic         mem_w_m_q, mem_w_m_d;
  logic [3:0]   wa3_m_q, wa3_m_d;
  logic [N-1:0] alu_result_m_q, alu_result_m_d;
  logic         f_n, f_z, f_c, f_v;
  logic         live;

  assign {f_n, f_z, f_c, f_v} = flags_q;

  // Evaluated on registered flags only; alu_flags is never bypassed in.
  always_comb begin
    cond_ex_e = 1'b1;
    case (cond_e)
      4'h0: cond_ex_e = f_z;
      4'h1: cond_ex_e = !f_z;
      4'h2: cond_ex_e = f_c;
      4'h3: cond_ex_e = !f_c;
      4'h4: cond_ex_e = f_n;
      4'h5: cond_ex_e = !f_n;
      4'h6: cond_ex_e = f_v;
      4'h7: cond_ex_e = !f_v;
      4'h8: cond_ex_e = f_c & !f_z;
      4'h9: cond_ex_e = !f_c | f_z;
      4'hA: cond_ex_e = (f_n == f_v);
      4'hB: cond_ex_e = (f_n != f_v);
      4'hC: cond_ex_e = !f_z & (f_n == f_v);
      4'hD: cond_ex_e = f_z | (f_n != f_v);
      default: cond_ex_e = 1'b1;
    endcase
  end

  assign live     = valid_e & cond_ex_e & !flush & !stall;
  assign pc_src_e = live & pc_s_e;

  always_comb begin
    flags_d        = flags_q;
    valid_m_d      = valid_m_q;
    reg_w_m_d      = reg_w_m_q;
    mem_w_m_d      = mem_w_m_q;
    wa3_m_d        = wa3_m_q;
    alu_result_m_d = alu_result_m_q;
    if (flush) begin
      valid_m_d = 1'b0;
      reg_w_m_d = 1'b0;
      mem_w_m_d = 1'b0;
    end else if (!stall) begin
      valid_m_d      = valid_e & cond_ex_e;
      reg_w_m_d      = live & reg_w_e;
      mem_w_m_d      = live & mem_w_e;
      wa3_m_d        = wa3_e;
      alu_result_m_d = alu_result;
      if (live && flag_w_e[1]) flags_d[3:2] = alu_flags[3:2];
      if (live && flag_w_e[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q        <= '0;
      valid_m_q      <= 1'b0;
      reg_w_m_q      <= 1'b0;
      mem_w_m_q      <= 1'b0;
      wa3_m_q        <= '0;
      alu_result_m_q <= '0;
    end else begin
      flags_q        <= flags_d;
      valid_m_q      <= valid_m_d;
      reg_w_m_q      <= reg_w_m_d;
      mem_w_m_q      <= mem_w_m_d;
      wa3_m_q        <= wa3_m_d;
      alu_result_m_q <= alu_result_m_d;
    end
  end

  assign flags        = flags_q;
  assign valid_m      = valid_m_q;
  assign reg_w_m      = reg_w_m_q;
  assign mem_w_m      = mem_w_m_q;
  assign wa3_m        = wa3_m_q;
  assign alu_result_m = alu_result_m_q;

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (valid_e && !cond_ex_e && !stall && !flush) squash_cnt_d = squash_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) squash_cnt_q <= '0;
    else       squash_cnt_q <= squash_cnt_d;
  end

  assign squash_cnt = squash_cnt_q;
`endif

endmodule
